// File: rtl/a51_pkg.sv
// Shared constants for the A5/1 pixel cipher: register geometry, tap masks,
// clock-bit positions, FSM encoding and default load/warm-up lengths.
package a51_pkg;

    localparam int X_LEN = 19;
    localparam int Y_LEN = 22;
    localparam int Z_LEN = 23;

    localparam logic [X_LEN-1:0] X_TAPS = 19'h72000;   // bits 13,16,17,18
    localparam logic [Y_LEN-1:0] Y_TAPS = 22'h300000;  // bits 20,21
    localparam logic [Z_LEN-1:0] Z_TAPS = 23'h700080;  // bits 7,20,21,22

    localparam int X_CLK = 8;
    localparam int Y_CLK = 10;
    localparam int Z_CLK = 10;

    localparam int A51_KEY_BITS   = 64;
    localparam int A51_FRAME_BITS = 22;
    localparam int A51_WARMUP     = 100;
    localparam int A51_PIX_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_KEY   = 3'd1,
        ST_LOAD_FRAME = 3'd2,
        ST_WARMUP     = 3'd3,
        ST_READY      = 3'd4,
        ST_GEN        = 3'd5,
        ST_OUT        = 3'd6
    } a51_state_e;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_pixel_cipher_if.sv
// Pixel stream handshake: input pixel channel and output pixel channel.
interface a51_pixel_cipher_if #(parameter int PIX_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;

    modport master (output in_valid, in_pixel, out_ready,
                    input  in_ready, out_valid, out_pixel);
    modport slave  (input  in_valid, in_pixel, out_ready,
                    output in_ready, out_valid, out_pixel);
endinterface

// File: rtl/a51_lfsr.sv
// One A5/1 shift register: new bit enters at index 0, optional injected bit
// is XORed into the feedback during key/frame load.
module a51_lfsr #(
    parameter int             LEN      = 19,
    parameter logic [LEN-1:0] TAP_MASK = {LEN{1'b0}},
    parameter int             CLK_IDX  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic inject_bit,
    input  logic clear,
    output logic msb,
    output logic clk_bit
);

    logic [LEN-1:0] r_q, r_d;

    function automatic logic parity_taps(input logic [LEN-1:0] v);
        return ^(v & TAP_MASK);
    endfunction

    // next register value: clear wins over shifting
    always_comb begin
        r_d = r_q;
        if (clear) begin
            r_d = {LEN{1'b0}};
        end else if (en) begin
            r_d = {r_q[LEN-2:0], parity_taps(r_q) ^ inject_bit};
        end else begin
            r_d = r_q;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= {LEN{1'b0}};
        end else begin
            r_q <= r_d;
        end
    end

    assign msb     = r_q[LEN-1];
    assign clk_bit = r_q[CLK_IDX];

endmodule

// File: rtl/a51_pixel_cipher.sv
// A5/1 keystream pixel cipher: loads key and frame, warms up, then XORs one
// keystream byte onto every pixel passing from source to sink.
module a51_pixel_cipher
    import a51_pkg::*;
#(
    parameter int KEY_BITS   = A51_KEY_BITS,
    parameter int FRAME_BITS = A51_FRAME_BITS,
    parameter int WARMUP     = A51_WARMUP,
    parameter int PIX_W      = A51_PIX_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    a51_pixel_cipher_if.slave     pix
);

    a51_state_e            state_q, state_d;
    logic [6:0]            cnt_q, cnt_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [PIX_W-1:0]      ks_q, ks_d;
    logic [PIX_W-1:0]      out_pixel_q, out_pixel_d;

    logic [2:0] lfsr_en_s;
    logic [2:0] msb_s;
    logic [2:0] clkb_s;
    logic       inject_s;
    logic       clear_s;
    logic       maj_s;
    logic       ks_bit_s;
    logic [2:0] maj_en_s;

    a51_lfsr #(.LEN(X_LEN), .TAP_MASK(X_TAPS), .CLK_IDX(X_CLK)) u_x (
        .clk(clk), .reset_n(reset_n), .en(lfsr_en_s[0]), .inject_bit(inject_s),
        .clear(clear_s), .msb(msb_s[0]), .clk_bit(clkb_s[0]));
    a51_lfsr #(.LEN(Y_LEN), .TAP_MASK(Y_TAPS), .CLK_IDX(Y_CLK)) u_y (
        .clk(clk), .reset_n(reset_n), .en(lfsr_en_s[1]), .inject_bit(inject_s),
        .clear(clear_s), .msb(msb_s[1]), .clk_bit(clkb_s[1]));
    a51_lfsr #(.LEN(Z_LEN), .TAP_MASK(Z_TAPS), .CLK_IDX(Z_CLK)) u_z (
        .clk(clk), .reset_n(reset_n), .en(lfsr_en_s[2]), .inject_bit(inject_s),
        .clear(clear_s), .msb(msb_s[2]), .clk_bit(clkb_s[2]));

    assign maj_s    = majority(clkb_s[0], clkb_s[1], clkb_s[2]);
    assign maj_en_s = {clkb_s[2] == maj_s, clkb_s[1] == maj_s, clkb_s[0] == maj_s};
    assign ks_bit_s = ^msb_s;

    // next-state, counter, load shifters and LFSR control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        frame_d     = frame_q;
        pix_d       = pix_q;
        ks_d        = ks_q;
        out_pixel_d = out_pixel_q;
        lfsr_en_s   = 3'b000;
        inject_s    = 1'b0;
        clear_s     = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    key_d   = key;
                    frame_d = frame;
                    clear_s = 1'b1;
                    cnt_d   = 7'd0;
                    state_d = ST_LOAD_KEY;
                end else if ((state_q == ST_READY) && pix.in_valid) begin
                    pix_d   = pix.in_pixel;
                    ks_d    = {PIX_W{1'b0}};
                    cnt_d   = 7'd0;
                    state_d = ST_GEN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD_KEY: begin
                lfsr_en_s = 3'b111;
                inject_s  = key_q[0];
                key_d     = {1'b0, key_q[KEY_BITS-1:1]};
                if (cnt_q == 7'(KEY_BITS - 1)) begin
                    cnt_d   = 7'd0;
                    state_d = ST_LOAD_FRAME;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_LOAD_FRAME: begin
                lfsr_en_s = 3'b111;
                inject_s  = frame_q[0];
                frame_d   = {1'b0, frame_q[FRAME_BITS-1:1]};
                if (cnt_q == 7'(FRAME_BITS - 1)) begin
                    cnt_d   = 7'd0;
                    state_d = ST_WARMUP;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_WARMUP: begin
                lfsr_en_s = maj_en_s;
                if (cnt_q == 7'(WARMUP - 1)) begin
                    cnt_d   = 7'd0;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_GEN: begin
                lfsr_en_s = maj_en_s;
                ks_d      = {ks_q[PIX_W-2:0], ks_bit_s};
                if (cnt_q == 7'(PIX_W - 1)) begin
                    out_pixel_d = pix_q ^ ks_d;
                    cnt_d       = 7'd0;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_OUT: begin
                if (pix.out_ready) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 7'd0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 7'd0;
            key_q       <= {KEY_BITS{1'b0}};
            frame_q     <= {FRAME_BITS{1'b0}};
            pix_q       <= {PIX_W{1'b0}};
            ks_q        <= {PIX_W{1'b0}};
            out_pixel_q <= {PIX_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            frame_q     <= frame_d;
            pix_q       <= pix_d;
            ks_q        <= ks_d;
            out_pixel_q <= out_pixel_d;
        end
    end

    assign busy          = (state_q == ST_LOAD_KEY) || (state_q == ST_LOAD_FRAME) ||
                           (state_q == ST_WARMUP);
    assign pix.in_ready  = (state_q == ST_READY);
    assign pix.out_valid = (state_q == ST_OUT);
    assign pix.out_pixel = out_pixel_q;

endmodule
